lcd_hd44780_responder: RTL and testbench

Synthesizable HD44780-compatible responder: the display end of the 8-bit parallel LCD bus that our LCD write FSMs drive. It samples LCD_EN/LCD_RS/LCD_RW/LCD_DATA on a fast system clock, decodes instructions, and keeps an 80-byte DDRAM, an address counter, display flags and a busy flag. It answers status and data reads. It is used as a bench/virtual-display model behind the LCD controllers and exposes the DDRAM contents through a side read port.

---
 rtl/lcd_hd44780_responder.sv | 192 +++++++++++++++++++
 tb/tb_lcd_hd44780_responder.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_hd44780_responder.sv
// HD44780-compatible display-side responder: 8-bit bus decode, 80-byte
// DDRAM, address counter, D/C/B flags, busy modelling and a side read port.
module lcd_hd44780_responder #(
    parameter int BUSY_CYCLES = 16
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic       LCD_EN,
    input  logic       LCD_RS,
    input  logic       LCD_RW,
    input  logic [7:0] LCD_DATA_IN,
    output logic [7:0] LCD_DATA_OUT,
    output logic       LCD_DATA_OE,
    input  logic [6:0] rd_addr,
    output logic [7:0] rd_char,
    output logic       disp_on,
    output logic       cursor_on,
    output logic       blink_on,
    output logic       busy,
    output logic [6:0] ac,
    output logic       err
);

    typedef enum logic [1:0] {
        S_FILL,
        S_BUSY,
        S_IDLE
    } state_t;

    state_t     state;
    logic       en_s1, en_s2, en_s3;
    logic       en_rise, en_fall;
    logic       lat_rs, lat_rw;
    logic [7:0] lat_d;
    logic [6:0] fill_idx;
    logic [7:0] cnt;
    logic       id, sh, dl, nl, fnt;
    logic [7:0] mem [0:79];
    logic       we;
    logic [6:0] waddr;
    logic [7:0] wdata;
    logic [6:0] cur_idx;
    logic       bad_access;

    function automatic logic [6:0] ac_step(input logic [6:0] a,
                                           input logic inc);
        if (inc) begin
            if (a == 7'h27) return 7'h40;
            if (a == 7'h67) return 7'h00;
            return a + 7'd1;
        end
        if (a == 7'h00) return 7'h67;
        if (a == 7'h40) return 7'h27;
        return a - 7'd1;
    endfunction

    function automatic logic addr_ok(input logic [6:0] a);
        return (a <= 7'h27) || (a >= 7'h40 && a <= 7'h67);
    endfunction

    assign en_rise = en_s2 & ~en_s3;
    assign en_fall = ~en_s2 & en_s3;
    assign busy    = (state != S_IDLE);
    assign cur_idx = ac[6] ? 7'd40 + {1'b0, ac[5:0]} : {1'b0, ac[5:0]};
    // Status reads are the only access tolerated outside IDLE.
    assign bad_access = en_fall && (state != S_IDLE) && (!lat_rw || lat_rs);

    always_comb begin
        we    = 1'b0;
        waddr = fill_idx;
        wdata = 8'h20;
        if (!reset) begin
            if (state == S_FILL) begin
                we = 1'b1;
            end else if (state == S_IDLE && en_fall && lat_rs && !lat_rw) begin
                we    = 1'b1;
                waddr = cur_idx;
                wdata = lat_d;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (we) mem[waddr] <= wdata;
        rd_char <= (rd_addr > 7'd79) ? 8'h20 : mem[rd_addr];
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            en_s1        <= 1'b0;
            en_s2        <= 1'b0;
            en_s3        <= 1'b0;
            lat_rs       <= 1'b0;
            lat_rw       <= 1'b0;
            lat_d        <= 8'h00;
            state        <= S_FILL;
            fill_idx     <= 7'd0;
            cnt          <= 8'd0;
            ac           <= 7'h00;
            id           <= 1'b1;
            sh           <= 1'b0;
            disp_on      <= 1'b0;
            cursor_on    <= 1'b0;
            blink_on     <= 1'b0;
            dl           <= 1'b1;
            nl           <= 1'b0;
            fnt          <= 1'b0;
            err          <= 1'b0;
            LCD_DATA_OE  <= 1'b0;
            LCD_DATA_OUT <= 8'h00;
        end else begin
            en_s1 <= LCD_EN;
            en_s2 <= en_s1;
            en_s3 <= en_s2;
            if (en_rise) begin
                lat_rs <= LCD_RS;
                lat_rw <= LCD_RW;
                lat_d  <= LCD_DATA_IN;
            end
            LCD_DATA_OE  <= 1'b0;
            LCD_DATA_OUT <= 8'h00;
            if (en_s1 && LCD_RW && (!LCD_RS || state == S_IDLE)) begin
                LCD_DATA_OE  <= 1'b1;
                LCD_DATA_OUT <= LCD_RS ? mem[cur_idx] : {busy, ac};
            end
            if (bad_access) err <= 1'b1;
            unique case (state)
                S_FILL: begin
                    fill_idx <= fill_idx + 7'd1;
                    if (fill_idx == 7'd79) begin
                        state <= S_BUSY;
                        cnt   <= 8'd0;
                    end
                end
                S_BUSY: begin
                    cnt <= cnt + 8'd1;
                    if (cnt == 8'(BUSY_CYCLES - 1)) state <= S_IDLE;
                end
                S_IDLE: begin
                    if (en_fall && !lat_rs && !lat_rw) begin
                        unique case (1'b1)
                            lat_d[7]: begin
                                if (addr_ok(lat_d[6:0])) ac <= lat_d[6:0];
                                else err <= 1'b1;
                            end
                            lat_d[7:6] == 2'b01: begin
                            end
                            lat_d[7:5] == 3'b001: begin
                                dl  <= lat_d[4];
                                nl  <= lat_d[3];
                                fnt <= lat_d[2];
                                if (!lat_d[4]) err <= 1'b1;
                            end
                            lat_d[7:4] == 4'b0001: begin
                                if (!lat_d[3]) ac <= ac_step(ac, lat_d[2]);
                            end
                            lat_d[7:3] == 5'b00001: begin
                                disp_on   <= lat_d[2];
                                cursor_on <= lat_d[1];
                                blink_on  <= lat_d[0];
                            end
                            lat_d[7:2] == 6'b000001: begin
                                id <= lat_d[1];
                                sh <= lat_d[0];
                            end
                            lat_d[7:1] == 7'b0000001: ac <= 7'h00;
                            lat_d == 8'h01: begin
                                ac <= 7'h00;
                                id <= 1'b1;
                            end
                            default: begin
                            end
                        endcase
                        if (lat_d == 8'h01) begin
                            state    <= S_FILL;
                            fill_idx <= 7'd0;
                        end else if (lat_d != 8'h00) begin
                            state <= S_BUSY;
                            cnt   <= 8'd0;
                        end
                    end else if (en_fall && lat_rs) begin
                        ac    <= ac_step(ac, id);
                        state <= S_BUSY;
                        cnt   <= 8'd0;
                    end
                end
                default: state <= S_FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_hd44780_responder.sv
// Randomized bench for lcd_hd44780_responder against a linear-position
// display model; directed reset, init, wrap, status and violation cases.
module tb_lcd_hd44780_responder;

    logic       CLK = 1'b0;
    logic       reset = 1'b0;
    logic       LCD_EN = 1'b0;
    logic       LCD_RS = 1'b0;
    logic       LCD_RW = 1'b0;
    logic [7:0] LCD_DATA_IN = 8'h00;
    logic [7:0] LCD_DATA_OUT;
    logic       LCD_DATA_OE;
    logic [6:0] rd_addr = 7'd0;
    logic [7:0] rd_char;
    logic       disp_on, cursor_on, blink_on, busy, err;
    logic [6:0] ac;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] m_mem [80];
    logic [6:0] m_ac;
    logic       m_id, m_d, m_c, m_b, m_err;

    always #5 CLK = ~CLK;

    lcd_hd44780_responder #(.BUSY_CYCLES(16)) dut (
        .CLK(CLK), .reset(reset),
        .LCD_EN(LCD_EN), .LCD_RS(LCD_RS), .LCD_RW(LCD_RW),
        .LCD_DATA_IN(LCD_DATA_IN), .LCD_DATA_OUT(LCD_DATA_OUT),
        .LCD_DATA_OE(LCD_DATA_OE), .rd_addr(rd_addr), .rd_char(rd_char),
        .disp_on(disp_on), .cursor_on(cursor_on), .blink_on(blink_on),
        .busy(busy), .ac(ac), .err(err)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Display positions 0..79 run line 1 then line 2.
    function automatic int pos_of(input logic [6:0] a);
        return a[6] ? 40 + int'(a[5:0]) : int'(a[5:0]);
    endfunction

    function automatic logic [6:0] ac_of(input int p);
        return (p < 40) ? 7'(p) : 7'(64 + p - 40);
    endfunction

    function automatic logic [6:0] m_step(input logic [6:0] a,
                                          input logic inc);
        return ac_of(inc ? (pos_of(a) + 1) % 80 : (pos_of(a) + 79) % 80);
    endfunction

    task automatic m_reset();
        foreach (m_mem[i]) m_mem[i] = 8'h20;
        m_ac = 0; m_id = 1; m_d = 0; m_c = 0; m_b = 0; m_err = 0;
    endtask

    task automatic m_exec(input logic rs, input logic rw,
                          input logic [7:0] d, output logic eb,
                          output logic [7:0] er);
        int a;
        eb = 0;
        er = 8'h00;
        if (rw && !rs) begin
            er = {1'b0, m_ac};
        end else if (rw) begin
            er = m_mem[pos_of(m_ac)];
            m_ac = m_step(m_ac, m_id);
            eb = 1;
        end else if (rs) begin
            m_mem[pos_of(m_ac)] = d;
            m_ac = m_step(m_ac, m_id);
            eb = 1;
        end else begin
            eb = (d != 0);
            if (d >= 128) begin
                a = int'(d) - 128;
                if (a <= 39 || (a >= 64 && a <= 103)) m_ac = 7'(a);
                else m_err = 1;
            end else if (d >= 64) begin
            end else if (d >= 32) begin
                if (!d[4]) m_err = 1;
            end else if (d >= 16) begin
                if (!d[3]) m_ac = m_step(m_ac, d[2]);
            end else if (d >= 8) begin
                m_d = d[2]; m_c = d[1]; m_b = d[0];
            end else if (d >= 4) begin
                m_id = d[1];
            end else if (d >= 2) begin
                m_ac = 0;
            end else if (d == 1) begin
                m_ac = 0;
                m_id = 1;
                foreach (m_mem[i]) m_mem[i] = 8'h20;
            end
        end
    endtask

    task automatic lcd_access(input logic rs, input logic rw,
                              input logic [7:0] d, output logic [7:0] rdat,
                              output logic oe_hi, output logic oe_lo);
        @(negedge CLK);
        LCD_RS = rs; LCD_RW = rw; LCD_DATA_IN = d;
        @(negedge CLK);
        LCD_EN = 1;
        repeat (5) @(negedge CLK);
        rdat = LCD_DATA_OUT;
        oe_hi = LCD_DATA_OE;
        LCD_EN = 0;
        repeat (6) @(negedge CLK);
        oe_lo = LCD_DATA_OE;
        LCD_RW = 0;
    endtask

    task automatic wait_ready();
        int k = 0;
        while (busy === 1'b1 && k < 400) begin
            @(negedge CLK);
            k++;
        end
        if (busy !== 1'b0) chk("ready_timeout", 32'(busy), 0);
    endtask

    task automatic read_char(input int i, output logic [7:0] v);
        @(negedge CLK);
        rd_addr = 7'(i);
        @(negedge CLK);
        v = rd_char;
    endtask

    task automatic do_op(input logic rs, input logic rw, input logic [7:0] d);
        logic eb, oh, ol;
        logic [7:0] er, rdat;
        wait_ready();
        m_exec(rs, rw, d, eb, er);
        lcd_access(rs, rw, d, rdat, oh, ol);
        if (rw) begin
            chk($sformatf("rd_data rs=%0d", rs), 32'(rdat), 32'(er));
            chk("rd_oe_high", 32'(oh), 1);
        end
        chk("oe_low", 32'(ol), 0);
        chk($sformatf("busy_after %0h", d), 32'(busy), 32'(eb));
        chk($sformatf("ac_after %0h", d), 32'(ac), 32'(m_ac));
        chk("err", 32'(err), 32'(m_err));
        chk("dcb", 32'({disp_on, cursor_on, blink_on}),
            32'({m_d, m_c, m_b}));
    endtask

    task automatic do_reset(input string tag);
        int n = 0;
        @(negedge CLK);
        reset = 1;
        @(negedge CLK);
        reset = 0;
        m_reset();
        chk({tag, "_oe"}, 32'(LCD_DATA_OE), 0);
        chk({tag, "_out"}, 32'(LCD_DATA_OUT), 0);
        chk({tag, "_ac"}, 32'(ac), 0);
        chk({tag, "_disp"}, 32'(disp_on), 0);
        chk({tag, "_err"}, 32'(err), 0);
        while (busy === 1'b1 && n < 500) begin
            n++;
            @(negedge CLK);
        end
        chk({tag, "_busy_cycles"}, n, 96);
    endtask

    initial begin
        logic [7:0] v, rdat;
        logic oh, ol;
        int k, p;
        do_reset("reset");
        read_char(0, v);  chk("reset_ch0", 32'(v), 32'h20);
        read_char(39, v); chk("reset_ch39", 32'(v), 32'h20);
        read_char(79, v); chk("reset_ch79", 32'(v), 32'h20);

        // Abort mid-fill: the count restarts from index 0.
        @(negedge CLK); reset = 1;
        @(negedge CLK); reset = 0;
        repeat (30) @(negedge CLK);
        do_reset("midreset");

        do_op(0, 0, 8'h38);
        do_op(0, 0, 8'h08);
        do_op(0, 0, 8'h01);
        do_op(0, 0, 8'h0C);
        do_op(0, 0, 8'h06);
        wait_ready();
        chk("init_disp", 32'(disp_on), 1);
        chk("init_cursor", 32'(cursor_on), 0);
        chk("init_blink", 32'(blink_on), 0);
        chk("init_ac", 32'(ac), 0);

        do_op(0, 0, 8'hA7);
        do_op(1, 0, "A");
        do_op(1, 0, "B");
        wait_ready();
        read_char(39, v); chk("wrap_ch39", 32'(v), 32'h41);
        read_char(40, v); chk("wrap_ch40", 32'(v), 32'h42);
        chk("wrap_ac", 32'(ac), 32'h41);

        do_op(0, 0, 8'h04);
        do_op(0, 0, 8'h80);
        do_op(1, 0, "Z");
        wait_ready();
        read_char(0, v); chk("decwrap_ch0", 32'(v), 32'h5A);
        chk("decwrap_ac", 32'(ac), 32'h67);

        do_op(0, 0, 8'h06);
        do_op(1, 0, "Q");
        lcd_access(0, 1, 8'h00, rdat, oh, ol);
        chk("status_busy", 32'(rdat), 32'({1'b1, m_ac}));
        chk("status_oe_hi", 32'(oh), 1);
        chk("status_oe_lo", 32'(ol), 0);
        repeat (20) @(negedge CLK);
        lcd_access(0, 1, 8'h00, rdat, oh, ol);
        chk("status_idle", 32'(rdat), 32'({1'b0, m_ac}));

        for (int i = 0; i < 150; i++) begin
            k = $urandom_range(0, 10);
            if (k <= 2) begin
                do_op(1, 0, 8'($urandom_range(32, 126)));
            end else if (k == 3) begin
                p = $urandom_range(0, 79);
                do_op(0, 0, {1'b1, ac_of(p)});
            end else if (k == 4) begin
                do_op(0, 0, 8'h04 | 8'($urandom_range(0, 3)));
            end else if (k == 5) begin
                do_op(0, 0, 8'h08 | 8'($urandom_range(0, 7)));
            end else if (k == 6) begin
                do_op(0, 0, 8'h10 | 8'($urandom_range(0, 15)));
            end else if (k == 7) begin
                p = $urandom_range(0, 9);
                if (p == 0) do_op(0, 0, 8'h01);
                else if (p == 1) do_op(0, 0, 8'h00);
                else if (p == 2) do_op(0, 0, 8'h40 | 8'($urandom_range(0, 63)));
                else do_op(0, 0, 8'h02 | 8'($urandom_range(0, 1)));
            end else if (k == 8) begin
                do_op(0, 0, 8'h30 | 8'($urandom_range(0, 15)));
            end else if (k == 9) begin
                do_op(0, 1, 8'h00);
            end else begin
                do_op(1, 1, 8'h00);
            end
        end
        wait_ready();
        for (int i = 0; i < 86; i++) begin
            read_char(i, v);
            chk($sformatf("ddram[%0d]", i), 32'(v),
                32'(i < 80 ? m_mem[i] : 8'h20));
        end
        read_char(127, v);
        chk("rd_char_127", 32'(v), 32'h20);

        do_op(0, 0, 8'h06);
        lcd_access(0, 0, 8'h41, rdat, oh, ol);
        m_err = 1;
        wait_ready();
        chk("busy_write_err", 32'(err), 1);
        chk("busy_write_ac", 32'(ac), 32'(m_ac));

        do_reset("reset2");
        do_op(0, 0, 8'h85);
        do_op(0, 0, 8'hB0);
        chk("bad_addr_ac", 32'(ac), 32'h05);
        chk("bad_addr_err", 32'(err), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
